// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and sequential instruction prefetcher
// Keeps a small FIFO of upcoming bytes filled from instruction RAM; one read in flight at most.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FETCH,
  input  logic              PC_LOAD,
  input  logic [ADDR_W-1:0] PC_IN,
  output logic [ADDR_W-1:0] IRAM_ADDR,
  output logic              IRAM_REQ,
  input  logic              IRAM_ACK,
  input  logic [DATA_W-1:0] IRAM_DATA,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              INSTR_VALID,
  output logic              STALL,
  output logic [ADDR_W-1:0] PC
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, faddr_q, faddr_d, iram_addr_q, iram_addr_d;
  logic              iram_req_q, iram_req_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d, pending_q, pending_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept, bypass, push, pop;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    faddr_d       = faddr_q;
    iram_addr_d   = iram_addr_q;
    iram_req_d    = iram_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pending_d     = pending_q;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    bypass        = 1'b0;
    pop           = 1'b0;
    // Data from a read issued against the old stream (DRAIN, or REQ+PC_LOAD) is never used.
    accept        = (state_q == S_REQ) && IRAM_ACK && !PC_LOAD;

    if (PC_LOAD) begin
      pc_d          = PC_IN;
      instr_valid_d = 1'b0;
      pending_d     = pending_q | FETCH;
    end else if (pending_q) begin
      bypass = accept;
    end else if (FETCH) begin
      if (count_q != '0) begin
        pop           = 1'b1;
        instr_d       = mem_q[rd_ptr_q];
        instr_valid_d = 1'b1;
        pc_d          = pc_q + ADDR_W'(1);
      end else if (accept) begin
        bypass = 1'b1;
      end else begin
        pending_d     = 1'b1;
        instr_valid_d = 1'b0;
      end
    end

    if (bypass) begin
      instr_d       = IRAM_DATA;
      instr_valid_d = 1'b1;
      pending_d     = 1'b0;
      pc_d          = pc_q + ADDR_W'(1);
    end
    push = accept && !bypass;

    if (PC_LOAD) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = IRAM_DATA;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (PC_LOAD)     faddr_d = PC_IN;
    else if (accept) faddr_d = faddr_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (count_d < CNT_W'(DEPTH)) begin
          state_d     = S_REQ;
          iram_req_d  = 1'b1;
          iram_addr_d = faddr_d;
        end
      end
      S_REQ: begin
        if (IRAM_ACK) begin
          if (!PC_LOAD && count_d < CNT_W'(DEPTH)) begin
            iram_addr_d = faddr_d;
          end else begin
            state_d    = S_IDLE;
            iram_req_d = 1'b0;
          end
        end else if (PC_LOAD) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (IRAM_ACK) begin
          state_d    = S_IDLE;
          iram_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        iram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      faddr_q       <= '0;
      iram_addr_q   <= '0;
      iram_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pending_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      faddr_q       <= faddr_d;
      iram_addr_q   <= iram_addr_d;
      iram_req_q    <= iram_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pending_q     <= pending_d;
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  assign IRAM_ADDR   = iram_addr_q;
  assign IRAM_REQ    = iram_req_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = instr_valid_q;
  assign STALL       = pending_q;
  assign PC          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
// RAM responder returns addr ^ 8'hA5 after a programmable number of wait cycles.
module tb_instr_fetch_unit;
  logic       CLOCK = 1'b0;
  logic       RESET, FETCH, PC_LOAD, IRAM_REQ, IRAM_ACK, INSTR_VALID, STALL;
  logic [7:0] PC_IN, IRAM_ADDR, IRAM_DATA, INSTRUCTION, PC;

  int         ncmp = 0;
  int         nerr = 0;
  int         ram_wait = 0;
  bit         ram_hold = 1'b0;
  int         wcnt = 0;
  logic [7:0] exp_pc = 8'h00;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];
  bit         ok;

  instr_fetch_unit dut (
    .CLOCK(CLOCK), .RESET(RESET), .FETCH(FETCH), .PC_LOAD(PC_LOAD), .PC_IN(PC_IN),
    .IRAM_ADDR(IRAM_ADDR), .IRAM_REQ(IRAM_REQ), .IRAM_ACK(IRAM_ACK), .IRAM_DATA(IRAM_DATA),
    .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID), .STALL(STALL), .PC(PC)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  always @(posedge CLOCK) begin
    #1;
    if (RESET || !IRAM_REQ) begin
      IRAM_ACK = 1'b0;
      wcnt     = 0;
    end else begin
      if (IRAM_ACK) wcnt = 0;
      if (!ram_hold && wcnt >= ram_wait) begin
        IRAM_ACK  = 1'b1;
        IRAM_DATA = mem_byte(IRAM_ADDR);
      end else begin
        IRAM_ACK = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic do_fetch();
    @(negedge CLOCK);
    FETCH = 1'b1;
    exp_q.push_back(mem_byte(exp_pc));
    exp_pc = exp_pc + 8'd1;
    @(negedge CLOCK);
    FETCH = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    int n = 0;
    while (INSTR_VALID !== 1'b1 && n < 40) begin
      @(negedge CLOCK);
      n++;
    end
    got = (INSTR_VALID === 1'b1);
  endtask

  task automatic load_pc(input logic [7:0] a, input logic with_fetch);
    @(negedge CLOCK);
    PC_LOAD = 1'b1; PC_IN = a; FETCH = with_fetch;
    exp_q.delete(); exp_pc = a;
    if (with_fetch) begin
      exp_q.push_back(mem_byte(exp_pc));
      exp_pc = exp_pc + 8'd1;
    end
    @(negedge CLOCK);
    PC_LOAD = 1'b0; FETCH = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK);
    ncmp++; if (INSTRUCTION !== 8'h00) begin nerr++; $display("FAIL reset_instr: got %0h want 0", INSTRUCTION); end
    ncmp++; if (INSTR_VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0b want 0", INSTR_VALID); end
    ncmp++; if (STALL !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %0b want 0", STALL); end
    ncmp++; if (PC !== 8'h00) begin nerr++; $display("FAIL reset_pc: got %0h want 0", PC); end
    ncmp++; if (IRAM_REQ !== 1'b0 || IRAM_ADDR !== 8'h00) begin nerr++; $display("FAIL reset_iram: got req=%0b addr=%0h want 0/0", IRAM_REQ, IRAM_ADDR); end
    RESET = 1'b0;
  endtask

  task automatic test_prefill();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      ncmp++;
      if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'(i)) begin
        nerr++; $display("FAIL prefill_req%0d: got req=%0b addr=%0h want 1/%0h", i, IRAM_REQ, IRAM_ADDR, i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK);
      ncmp++; if (IRAM_REQ !== 1'b0) begin nerr++; $display("FAIL prefill_full_idle: got req=%0b want 0", IRAM_REQ); end
    end
    do_fetch();
    wait_valid(ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL prefill_timeout: got valid=0 want 1"); end
    exp_b = exp_q.pop_front();
    ncmp++; if (INSTRUCTION !== exp_b) begin nerr++; $display("FAIL prefill_byte: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (PC !== exp_pc) begin nerr++; $display("FAIL prefill_pc: got %0h want %0h", PC, exp_pc); end
    ncmp++; if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'h04) begin nerr++; $display("FAIL prefill_refill: got req=%0b addr=%0h want 1/4", IRAM_REQ, IRAM_ADDR); end
  endtask

  task automatic test_pc_load_drain();
    int n = 0;
    repeat (10) @(negedge CLOCK);
    ram_hold = 1'b1;
    do_fetch();
    wait_valid(ok);
    exp_b = exp_q.pop_front();
    ncmp++; if (!ok || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL drain_pre_byte: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'h05) begin nerr++; $display("FAIL drain_outstanding: got req=%0b addr=%0h want 1/5", IRAM_REQ, IRAM_ADDR); end
    load_pc(8'h40, 1'b0);
    ncmp++; if (INSTR_VALID !== 1'b0) begin nerr++; $display("FAIL drain_valid_clr: got %0b want 0", INSTR_VALID); end
    for (int i = 0; i < 2; i++) begin
      ncmp++; if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'h05) begin nerr++; $display("FAIL drain_hold%0d: got req=%0b addr=%0h want 1/5", i, IRAM_REQ, IRAM_ADDR); end
      @(negedge CLOCK);
    end
    ram_hold = 1'b0;
    while (!(IRAM_REQ === 1'b1 && IRAM_ADDR !== 8'h05) && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    ncmp++; if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'h40) begin nerr++; $display("FAIL drain_new_addr: got req=%0b addr=%0h want 1/40", IRAM_REQ, IRAM_ADDR); end
    do_fetch();
    wait_valid(ok);
    exp_b = exp_q.pop_front();
    ncmp++; if (!ok || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL drain_byte40: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (PC !== 8'h41) begin nerr++; $display("FAIL drain_pc: got %0h want 41", PC); end
  endtask

  task automatic test_stall();
    int stalls = 0;
    int n = 0;
    repeat (12) @(negedge CLOCK);
    ram_wait = 3;
    load_pc(8'h20, 1'b0);
    FETCH = 1'b1;
    exp_q.push_back(mem_byte(exp_pc));
    exp_pc = exp_pc + 8'd1;
    @(negedge CLOCK);
    FETCH = 1'b0;
    while (STALL === 1'b1 && n < 20) begin
      ncmp++; if (INSTR_VALID !== 1'b0) begin nerr++; $display("FAIL stall_valid: got %0b want 0", INSTR_VALID); end
      stalls++;
      @(negedge CLOCK);
      n++;
    end
    ncmp++; if (stalls != 3) begin nerr++; $display("FAIL stall_cycles: got %0d want 3", stalls); end
    ncmp++; if (INSTR_VALID !== 1'b1) begin nerr++; $display("FAIL stall_deliver_valid: got %0b want 1", INSTR_VALID); end
    exp_b = exp_q.pop_front();
    ncmp++; if (INSTRUCTION !== exp_b) begin nerr++; $display("FAIL stall_byte: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (PC !== exp_pc) begin nerr++; $display("FAIL stall_pc: got %0h want %0h", PC, exp_pc); end
  endtask

  task automatic test_load_with_fetch();
    int n = 0;
    load_pc(8'h10, 1'b1);
    ncmp++; if (STALL !== 1'b1 || INSTR_VALID !== 1'b0) begin nerr++; $display("FAIL loadfetch_stall: got stall=%0b valid=%0b want 1/0", STALL, INSTR_VALID); end
    while (INSTR_VALID !== 1'b1 && n < 40) begin
      ncmp++; if (STALL !== 1'b1) begin nerr++; $display("FAIL loadfetch_stall_hold: got %0b want 1", STALL); end
      @(negedge CLOCK);
      n++;
    end
    ncmp++; if (INSTR_VALID !== 1'b1 || STALL !== 1'b0) begin nerr++; $display("FAIL loadfetch_deliver: got valid=%0b stall=%0b want 1/0", INSTR_VALID, STALL); end
    exp_b = exp_q.pop_front();
    ncmp++; if (INSTRUCTION !== exp_b) begin nerr++; $display("FAIL loadfetch_byte: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (PC !== 8'h11) begin nerr++; $display("FAIL loadfetch_pc: got %0h want 11", PC); end
    ram_wait = 0;
  endtask

  task automatic test_wrap();
    repeat (10) @(negedge CLOCK);
    load_pc(8'hFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_fetch();
      wait_valid(ok);
      exp_b = exp_q.pop_front();
      ncmp++; if (!ok || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL wrap_byte%0d: got %0h want %0h", i, INSTRUCTION, exp_b); end
      ncmp++; if (PC !== exp_pc) begin nerr++; $display("FAIL wrap_pc%0d: got %0h want %0h", i, PC, exp_pc); end
    end
    ncmp++; if (PC !== 8'h01) begin nerr++; $display("FAIL wrap_final_pc: got %0h want 01", PC); end
  endtask

  task automatic test_back_to_back();
    repeat (10) @(negedge CLOCK);
    FETCH = 1'b1;
    exp_q.push_back(mem_byte(exp_pc));
    exp_pc = exp_pc + 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      exp_b = exp_q.pop_front();
      ncmp++; if (INSTR_VALID !== 1'b1 || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL b2b_byte%0d: got valid=%0b %0h want 1/%0h", i, INSTR_VALID, INSTRUCTION, exp_b); end
      ncmp++; if (PC !== exp_pc) begin nerr++; $display("FAIL b2b_pc%0d: got %0h want %0h", i, PC, exp_pc); end
      if (i < 4) begin
        exp_q.push_back(mem_byte(exp_pc));
        exp_pc = exp_pc + 8'd1;
      end else begin
        FETCH = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_req();
    repeat (10) @(negedge CLOCK);
    ram_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_fetch();
      wait_valid(ok);
      exp_b = exp_q.pop_front();
      ncmp++; if (!ok || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL midreq_pre%0d: got %0h want %0h", i, INSTRUCTION, exp_b); end
    end
    ncmp++; if (IRAM_REQ !== 1'b1) begin nerr++; $display("FAIL midreq_outstanding: got %0b want 1", IRAM_REQ); end
    #2 RESET = 1'b1;
    #1;
    ncmp++; if (INSTRUCTION !== 8'h00 || INSTR_VALID !== 1'b0 || STALL !== 1'b0) begin nerr++; $display("FAIL midreq_async_out: got %0h/%0b/%0b want 0/0/0", INSTRUCTION, INSTR_VALID, STALL); end
    ncmp++; if (PC !== 8'h00 || IRAM_REQ !== 1'b0 || IRAM_ADDR !== 8'h00) begin nerr++; $display("FAIL midreq_async_iram: got pc=%0h req=%0b addr=%0h want 0/0/0", PC, IRAM_REQ, IRAM_ADDR); end
    @(negedge CLOCK);
    RESET = 1'b0; ram_hold = 1'b0;
    exp_q.delete(); exp_pc = 8'h00;
    @(negedge CLOCK);
    ncmp++; if (IRAM_REQ !== 1'b1 || IRAM_ADDR !== 8'h00) begin nerr++; $display("FAIL midreq_restart: got req=%0b addr=%0h want 1/0", IRAM_REQ, IRAM_ADDR); end
    do_fetch();
    wait_valid(ok);
    exp_b = exp_q.pop_front();
    ncmp++; if (!ok || INSTRUCTION !== exp_b) begin nerr++; $display("FAIL midreq_byte0: got %0h want %0h", INSTRUCTION, exp_b); end
    ncmp++; if (PC !== 8'h01) begin nerr++; $display("FAIL midreq_pc: got %0h want 01", PC); end
  endtask

  initial begin
    RESET = 1'b1; FETCH = 1'b0; PC_LOAD = 1'b0; PC_IN = 8'h00;
    IRAM_ACK = 1'b0; IRAM_DATA = 8'h00;
    test_reset();
    test_prefill();
    test_pc_load_drain();
    test_stall();
    test_load_with_fetch();
    test_wrap();
    test_back_to_back();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
